// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM encoding and counter sizing for serial arithmetic
package arith_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2} state_t;
  function automatic int clog2_min1(input int n);
    return n <= 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial a+b+cin with start/busy/done handshake
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = clog2_min1(WIDTH);
  state_t state;
  logic [WIDTH-1:0] ra, rb, p, pn;
  logic [CW-1:0] cnt;
  logic c, s, cn, go, last;
  full_adder u_fa (.a(ra[0]), .b(rb[0]), .cin(c), .sum(s), .carry(cn));
  assign pn = WIDTH'({s, p} >> 1);
  assign last = cnt == CW'(WIDTH - 1);
  assign go = start && state != ADD;
  assign busy = state == ADD;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      p <= '0;
      c <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else if (go) begin
      ra <= a;
      rb <= b;
      c <= cin;
      p <= '0;
      cnt <= '0;
      state <= ADD;
    end else if (state == ADD) begin
      ra <= ra >> 1;
      rb <= rb >> 1;
      c <= cn;
      p <= pn;
      cnt <= cnt + 1'b1;
      if (last) begin
        state <= DONE;
        sum <= pn;
        cout <= cn;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH=8 and WIDTH=1 against a counter model
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st8 = 1'b0, st1 = 1'b0, ci8 = 1'b0, ci1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic a1 = 1'b0, b1 = 1'b0, s1;
  logic bz8, dn8, co8, bz1, dn1, co1;
  int n_chk = 0, n_fail = 0;
  bit armed = 0;
  int left[2];
  logic md[2];
  logic [8:0] pend[2], res[2];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(ci8),
    .busy(bz8), .done(dn8), .sum(s8), .cout(co8)
  );
  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .cin(ci1),
    .busy(bz1), .done(dn1), .sum(s1), .cout(co1)
  );

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        left[i] = 0;
        md[i] = 1'b0;
        res[i] = '0;
      end else if (left[i] > 0) begin
        left[i]--;
        if (left[i] == 0) begin
          md[i] = 1'b1;
          res[i] = pend[i];
        end
      end else begin
        md[i] = 1'b0;
        if (i == 0 ? st8 : st1) begin
          left[i] = i == 0 ? 8 : 1;
          pend[i] = i == 0 ? 9'(a8) + 9'(b8) + 9'(ci8) : 9'(a1) + 9'(b1) + 9'(ci1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy8", bz8, left[0] > 0);
      chk("done8", dn8, md[0]);
      chk("sum8", s8, res[0][7:0]);
      chk("cout8", co8, res[0][8]);
      chk("busy1", bz1, left[1] > 0);
      chk("done1", dn1, md[1]);
      chk("sum1", s1, res[1][0]);
      chk("cout1", co1, res[1][1]);
    end
  end

  task automatic run(input bit w1, input logic [7:0] x, input logic [7:0] y, input logic c,
                     input logic [7:0] es, input logic ec, input int lat, input bit keep);
    int cyc;
    if (w1) begin
      st1 = 1'b1; a1 = x[0]; b1 = y[0]; ci1 = c;
    end else begin
      st8 = 1'b1; a8 = x; b8 = y; ci8 = c;
    end
    @(posedge clk); #1;
    if (!keep) begin
      st8 = 1'b0;
      st1 = 1'b0;
    end
    cyc = 1;
    while (!(w1 ? dn1 : dn8) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, lat);
    chk("result_sum", w1 ? {7'b0, s1} : s8, es);
    chk("result_cout", w1 ? co1 : co8, ec);
  endtask

  initial begin
    int cyc, nd;
    logic [7:0] fs, fc;
    logic [2:0] k3;
    fs = 8'h96;
    fc = 8'hE8;
    @(posedge clk); #1;
    armed = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_busy", bz8, 0);
    chk("reset_done", dn8, 0);
    chk("reset_sum", s8, 0);
    chk("reset_cout", co8, 0);
    run(0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 9, 0);
    run(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 9, 0);
    run(0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 9, 0);
    run(0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 9, 1);
    run(0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 9, 0);
    st8 = 1'b1; a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    st8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    @(posedge clk); #1;
    st8 = 1'b0;
    cyc = 4;
    while (!dn8 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ignore_latency", cyc, 9);
    chk("ignore_sum", s8, 8'h30);
    nd = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (dn8) nd++;
    end
    chk("extra_done", nd, 0);
    st8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", bz8, 0);
    chk("abort_done", dn8, 0);
    chk("abort_sum", s8, 0);
    chk("abort_cout", co8, 0);
    rst = 1'b0;
    run(0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 9, 0);
    for (int k = 0; k < 8; k++) begin
      k3 = 3'(k);
      run(1, {7'b0, k3[2]}, {7'b0, k3[1]}, k3[0], {7'b0, fs[k]}, fc[k], 2, 0);
    end
    repeat (3) begin @(posedge clk); #1; end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
